// File: rtl/perspective_divide.sv
// Perspective divide stage: x/w, y/w, z/w for three vertices on one shared
// sign-magnitude restoring divider. Optional feature macro: PERSP_CULL_EN.
module perspective_divide #(
  parameter int FRAC_BITS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] x_in [3:0],
  input  logic [31:0] y_in [3:0],
  input  logic [31:0] z_in [3:0],
  input  logic [31:0] w_in [3:0],
  input  logic [23:0] color_in1,
  input  logic [23:0] color_in2,
  input  logic [23:0] color_in3,
  input  logic        input_data_valid,
  input  logic        done_in,
  input  logic        stall_in,
  output logic [31:0] x_out [2:0],
  output logic [31:0] y_out [2:0],
  output logic [31:0] z_out [2:0],
  output logic [23:0] color_out1,
  output logic [23:0] color_out2,
  output logic [23:0] color_out3,
  output logic        out_data_valid,
  output logic        done_out,
  output logic        stall_out,
  output logic        div_zero
);

  localparam int ITER = 32 + FRAC_BITS;
  localparam int DW   = 32 + FRAC_BITS;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(ITER);
  localparam logic [DW-1:0] MAX_POS  = DW'(32'h7FFF_FFFF);
  localparam logic [DW-1:0] MAX_NEG  = DW'(32'h8000_0000);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DIV  = 3'd1;
  localparam logic [2:0] S_PUB  = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  logic [2:0]    state_q;
  logic [31:0]   xs_q [2:0];
  logic [31:0]   ys_q [2:0];
  logic [31:0]   zs_q [2:0];
  logic [31:0]   ws_q [2:0];
  logic [23:0]   col1_q, col2_q, col3_q;
  logic          done_q;
  logic [1:0]    vtx_q, comp_q;
  logic [CW-1:0] cyc_q;
  logic [31:0]   rem_q;
  logic [32:0]   dvs_q;
  logic [DW-1:0] dvd_q, quo_q;
  logic          neg_q, wz_q, an_q;

  logic [31:0]   xv_s, yv_s, zv_s, wv_s, op_s, res_s;
  logic [32:0]   mag_s, rem_sh_s, rem_nx_s;
  logic          qbit_s;
  logic [DW-1:0] quo_nx_s;
  logic          unused_s;

  // Magnitude in 33 bits so that -0x80000000 cannot overflow.
  function automatic logic [32:0] abs33(input logic [31:0] v);
    logic [32:0] sv;
    sv = {v[31], v};
    if (v[31]) begin
      return 33'd0 - sv;
    end else begin
      return sv;
    end
  endfunction

  function automatic logic [31:0] finalize(input logic [DW-1:0] q, input logic neg,
                                           input logic wz, input logic a_neg);
    if (wz) begin
      return a_neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (neg) begin
      return (q > MAX_NEG) ? 32'h8000_0000 : (32'd0 - q[31:0]);
    end else begin
      return (q > MAX_POS) ? 32'h7FFF_FFFF : q[31:0];
    end
  endfunction

  assign stall_out = (state_q != S_IDLE);
  assign unused_s  = ^{x_in[3], y_in[3], z_in[3], w_in[3], rem_nx_s[32], mag_s[32]};

`ifdef PERSP_CULL_EN
  logic cull_s;
  assign cull_s = ($signed(w_in[0]) <= 32'sd0) || ($signed(w_in[1]) <= 32'sd0) ||
                  ($signed(w_in[2]) <= 32'sd0);
`endif

  // Operand selection and one restoring-divider step.
  always_comb begin
    xv_s = 32'd0;
    yv_s = 32'd0;
    zv_s = 32'd0;
    wv_s = 32'd0;
    case (vtx_q)
      2'd0:    begin xv_s = xs_q[0]; yv_s = ys_q[0]; zv_s = zs_q[0]; wv_s = ws_q[0]; end
      2'd1:    begin xv_s = xs_q[1]; yv_s = ys_q[1]; zv_s = zs_q[1]; wv_s = ws_q[1]; end
      2'd2:    begin xv_s = xs_q[2]; yv_s = ys_q[2]; zv_s = zs_q[2]; wv_s = ws_q[2]; end
      default: begin xv_s = 32'd0;   yv_s = 32'd0;   zv_s = 32'd0;   wv_s = 32'd0;   end
    endcase
    case (comp_q)
      2'd0:    op_s = xv_s;
      2'd1:    op_s = yv_s;
      2'd2:    op_s = zv_s;
      default: op_s = 32'd0;
    endcase
    mag_s    = abs33(op_s);
    rem_sh_s = {1'b0, rem_q[30:0], dvd_q[DW-1]} | {rem_q[31], 32'd0};
    if (rem_sh_s >= dvs_q) begin
      rem_nx_s = rem_sh_s - dvs_q;
      qbit_s   = 1'b1;
    end else begin
      rem_nx_s = rem_sh_s;
      qbit_s   = 1'b0;
    end
    quo_nx_s = {quo_q[DW-2:0], qbit_s};
    res_s    = finalize(quo_nx_s, neg_q, wz_q, an_q);
  end

  // Stage FSM, operand latch, divider registers and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      out_data_valid <= 1'b0;
      done_out       <= 1'b0;
      div_zero       <= 1'b0;
      color_out1     <= 24'd0;
      color_out2     <= 24'd0;
      color_out3     <= 24'd0;
      for (int i = 0; i < 3; i++) begin
        x_out[i] <= 32'd0;
        y_out[i] <= 32'd0;
        z_out[i] <= 32'd0;
        xs_q[i]  <= 32'd0;
        ys_q[i]  <= 32'd0;
        zs_q[i]  <= 32'd0;
        ws_q[i]  <= 32'd0;
      end
      col1_q <= 24'd0;
      col2_q <= 24'd0;
      col3_q <= 24'd0;
      done_q <= 1'b0;
      vtx_q  <= 2'd0;
      comp_q <= 2'd0;
      cyc_q  <= '0;
      rem_q  <= 32'd0;
      dvs_q  <= 33'd0;
      dvd_q  <= '0;
      quo_q  <= '0;
      neg_q  <= 1'b0;
      wz_q   <= 1'b0;
      an_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (input_data_valid) begin
            for (int i = 0; i < 3; i++) begin
              xs_q[i] <= x_in[i];
              ys_q[i] <= y_in[i];
              zs_q[i] <= z_in[i];
              ws_q[i] <= w_in[i];
            end
            col1_q <= color_in1;
            col2_q <= color_in2;
            col3_q <= color_in3;
            done_q <= done_in;
            vtx_q  <= 2'd0;
            comp_q <= 2'd0;
            cyc_q  <= '0;
`ifdef PERSP_CULL_EN
            if (cull_s) begin
              if (done_in) begin
                // Keep the end-of-stream marker alive with an empty triangle.
                for (int i = 0; i < 3; i++) begin
                  x_out[i] <= 32'd0;
                  y_out[i] <= 32'd0;
                  z_out[i] <= 32'd0;
                end
                color_out1     <= 24'd0;
                color_out2     <= 24'd0;
                color_out3     <= 24'd0;
                done_out       <= 1'b1;
                out_data_valid <= 1'b1;
                state_q        <= S_OUT;
              end else begin
                state_q <= S_DROP;
              end
            end else begin
              state_q <= S_DIV;
            end
`else
            state_q <= S_DIV;
`endif
          end
        end
        S_DIV: begin
          if (cyc_q == '0) begin
            rem_q <= 32'd0;
            dvs_q <= abs33(wv_s);
            dvd_q <= {mag_s[31:0], {FRAC_BITS{1'b0}}};
            quo_q <= '0;
            neg_q <= op_s[31] ^ wv_s[31];
            wz_q  <= (wv_s == 32'd0);
            an_q  <= op_s[31];
            if (wv_s == 32'd0) begin
              div_zero <= 1'b1;
            end
            cyc_q <= CW'(1);
          end else begin
            // A zero divisor skips the iterations but keeps the cycle count.
            if (!wz_q) begin
              rem_q <= rem_nx_s[31:0];
              dvd_q <= {dvd_q[DW-2:0], 1'b0};
              quo_q <= quo_nx_s;
            end
            if (cyc_q == CYC_LAST) begin
              case (comp_q)
                2'd0:    x_out[vtx_q] <= res_s;
                2'd1:    y_out[vtx_q] <= res_s;
                default: z_out[vtx_q] <= res_s;
              endcase
              cyc_q <= '0;
              if (comp_q == 2'd2) begin
                comp_q <= 2'd0;
                vtx_q  <= vtx_q + 2'd1;
                if (vtx_q == 2'd2) begin
                  state_q <= S_PUB;
                end
              end else begin
                comp_q <= comp_q + 2'd1;
              end
            end else begin
              cyc_q <= cyc_q + CW'(1);
            end
          end
        end
        S_PUB: begin
          color_out1     <= col1_q;
          color_out2     <= col2_q;
          color_out3     <= col3_q;
          done_out       <= done_q;
          out_data_valid <= 1'b1;
          state_q        <= S_OUT;
        end
        S_OUT: begin
          if (!stall_in) begin
            out_data_valid <= 1'b0;
            state_q        <= S_IDLE;
          end
        end
        S_DROP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perspective_divide.sv
// Randomized self-checking bench for perspective_divide against an
// arithmetic reference model of the fixed-point divide.
module tb_perspective_divide;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] xi [3:0];
  logic [31:0] yi [3:0];
  logic [31:0] zi [3:0];
  logic [31:0] wi [3:0];
  logic [23:0] c1, c2, c3;
  logic        ivalid, done_i, stall_i;
  logic [31:0] xo [2:0];
  logic [31:0] yo [2:0];
  logic [31:0] zo [2:0];
  logic [23:0] co1, co2, co3;
  logic        ovalid, done_o, stall_o, dz;

  int errors = 0;
  int checks = 0;

  logic [31:0] ex [3];
  logic [31:0] ey [3];
  logic [31:0] ez [3];
  logic [23:0] ec1, ec2, ec3;
  logic        ed;
  logic        exp_dz;

  always #5 clock = ~clock;

  perspective_divide dut (
    .clock(clock), .reset(reset),
    .x_in(xi), .y_in(yi), .z_in(zi), .w_in(wi),
    .color_in1(c1), .color_in2(c2), .color_in3(c3),
    .input_data_valid(ivalid), .done_in(done_i), .stall_in(stall_i),
    .x_out(xo), .y_out(yo), .z_out(zo),
    .color_out1(co1), .color_out2(co2), .color_out3(co3),
    .out_data_valid(ovalid), .done_out(done_o), .stall_out(stall_o), .div_zero(dz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // (a * 2^16) / w, truncated toward zero, saturated to 32-bit signed.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] w);
    longint sa, sw, ma, mw, q;
    sa = longint'($signed(a));
    sw = longint'($signed(w));
    if (sw == 0) return (sa >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    ma = ((sa < 0) ? -sa : sa) * 64'sd65536;
    mw = (sw < 0) ? -sw : sw;
    q  = ma / mw;
    if ((sa < 0) != (sw < 0)) begin
      if (q > 64'sd2147483648) return 32'h8000_0000;
      return 32'(-q);
    end
    if (q > 64'sd2147483647) return 32'h7FFF_FFFF;
    return 32'(q);
  endfunction

  function automatic logic [31:0] rnd_coord();
    logic [31:0] v;
    if ($urandom_range(0, 7) == 0) return 32'h8000_0000;
    v = $urandom >> $urandom_range(0, 16);
    return ($urandom_range(0, 1) == 1) ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] rnd_w();
    logic [31:0] m;
    m = $urandom_range(1, 32'h0003_FFFF);
`ifdef PERSP_CULL_EN
    return m;
`else
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'd0 - m;
      3:       return m;
      4:       return $urandom;
      default: return m << $urandom_range(0, 8);
    endcase
`endif
  endfunction

  task automatic rnd_tri();
    for (int v = 0; v < 4; v++) begin
      xi[v] = rnd_coord();
      yi[v] = rnd_coord();
      zi[v] = rnd_coord();
      wi[v] = rnd_w();
    end
    c1 = 24'($urandom); c2 = 24'($urandom); c3 = 24'($urandom);
    done_i = 1'($urandom_range(0, 1));
  endtask

  task automatic set_expect();
    for (int v = 0; v < 3; v++) begin
      ex[v] = ref_div(xi[v], wi[v]);
      ey[v] = ref_div(yi[v], wi[v]);
      ez[v] = ref_div(zi[v], wi[v]);
      if (wi[v] == 32'd0) exp_dz = 1'b1;
    end
    ec1 = c1; ec2 = c2; ec3 = c3; ed = done_i;
  endtask

  task automatic send();
    int n;
    set_expect();
    n = 0;
    while (stall_o && n < 2000) begin
      @(posedge clock); #1; n++;
    end
    check("ready_before_accept", 32'(stall_o), 32'd0);
    ivalid = 1'b1;
    @(posedge clock); #1;
    ivalid = 1'b0;
    check("busy_after_accept", 32'(stall_o), 32'd1);
  endtask

  task automatic collect();
    int n;
    n = 0;
    while (!ovalid && n < 1000) begin
      @(posedge clock); #1; n++;
    end
    check("latency", 32'(n), 32'd442);
    for (int v = 0; v < 3; v++) begin
      check($sformatf("x_out%0d", v), xo[v], ex[v]);
      check($sformatf("y_out%0d", v), yo[v], ey[v]);
      check($sformatf("z_out%0d", v), zo[v], ez[v]);
    end
    check("color1", 32'(co1), 32'(ec1));
    check("color2", 32'(co2), 32'(ec2));
    check("color3", 32'(co3), 32'(ec3));
    check("done_out", 32'(done_o), 32'(ed));
    check("div_zero", 32'(dz), 32'(exp_dz));
  endtask

  task automatic handoff();
    stall_i = 1'b0;
    @(posedge clock); #1;
    check("valid_falls", 32'(ovalid), 32'd0);
    check("idle_after_handoff", 32'(stall_o), 32'd0);
  endtask

  task automatic all_w(input logic [31:0] w);
    for (int v = 0; v < 4; v++) begin
      xi[v] = 32'd0; yi[v] = 32'd0; zi[v] = 32'd0; wi[v] = w;
    end
    c1 = 24'h112233; c2 = 24'h445566; c3 = 24'h778899; done_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ivalid = 1'b0; stall_i = 1'b0; exp_dz = 1'b0;
    all_w(32'h0002_0000);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_valid", 32'(ovalid), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_div_zero", 32'(dz), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_x0", xo[0], 32'd0);

    // Basic vector with known constants.
    all_w(32'h0002_0000);
    xi[0] = 32'h0002_0000; yi[0] = 32'hFFFD_0000; zi[0] = 32'h0001_0000;
    send(); collect();
    check("vec_x0", xo[0], 32'h0001_0000);
    check("vec_y0", yo[0], 32'hFFFE_8000);
    check("vec_z0", zo[0], 32'h0000_8000);
    handoff();

    // Truncation toward zero in both signs.
    all_w(32'h0003_0000);
    xi[0] = 32'h0001_0000; xi[1] = 32'hFFFF_0000; done_i = 1'b1;
    send(); collect();
    check("trunc_pos", xo[0], 32'h0000_5555);
    check("trunc_neg", xo[1], 32'hFFFF_AAAB);
    handoff();

`ifdef PERSP_CULL_EN
    all_w(32'h0002_0000);
    wi[2] = 32'hFFFF_0000;
    ivalid = 1'b1;
    @(posedge clock); #1;
    ivalid = 1'b0;
    repeat (20) begin
      @(posedge clock); #1;
      check("cull_no_output", 32'(ovalid), 32'd0);
    end
    check("cull_idle", 32'(stall_o), 32'd0);
    done_i = 1'b1;
    stall_i = 1'b1;
    ivalid = 1'b1;
    @(posedge clock); #1;
    ivalid = 1'b0;
    check("cull_done_valid", 32'(ovalid), 32'd1);
    check("cull_done_out", 32'(done_o), 32'd1);
    check("cull_x0", xo[0], 32'd0);
    check("cull_z2", zo[2], 32'd0);
    check("cull_color1", 32'(co1), 32'd0);
    handoff();
`else
    // Zero divisor in vertex 1, plus the most negative w and coordinate.
    all_w(32'h0002_0000);
    wi[1] = 32'd0; xi[1] = 32'h0005_0000; yi[1] = 32'hFFFB_0000;
    wi[2] = 32'h8000_0000; xi[2] = 32'h8000_0000;
    send(); collect();
    check("wz_x1", xo[1], 32'h7FFF_FFFF);
    check("wz_y1", yo[1], 32'h8000_0000);
    check("wz_flag", 32'(dz), 32'd1);
    check("minneg_x2", xo[2], 32'h0001_0000);
    handoff();
    all_w(32'h0001_0000);
    xi[0] = 32'h0004_0000;
    send(); collect();
    check("div_zero_sticky", 32'(dz), 32'd1);
    handoff();
`endif

    // Downstream stall with a competing upstream triangle.
    rnd_tri();
    stall_i = 1'b1;
    send(); collect();
    rnd_tri();
    ivalid = 1'b1;
    repeat (20) begin
      @(posedge clock); #1;
      check("stall_valid", 32'(ovalid), 32'd1);
      check("stall_busy", 32'(stall_o), 32'd1);
      check("stall_hold_x0", xo[0], ex[0]);
      check("stall_hold_z2", zo[2], ez[2]);
    end
    stall_i = 1'b0;
    @(posedge clock); #1;
    check("release_valid", 32'(ovalid), 32'd0);
    check("release_idle", 32'(stall_o), 32'd0);
    set_expect();
    @(posedge clock); #1;
    ivalid = 1'b0;
    check("next_accepted", 32'(stall_o), 32'd1);
    collect();
    handoff();

    // Reset in the middle of a division.
    rnd_tri();
    send();
    repeat (99) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_dz = 1'b0;
    check("midrst_valid", 32'(ovalid), 32'd0);
    check("midrst_idle", 32'(stall_o), 32'd0);
    check("midrst_div_zero", 32'(dz), 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (460) begin
        @(posedge clock); #1;
        if (ovalid) seen++;
      end
      check("midrst_no_emit", 32'(seen), 32'd0);
    end
    rnd_tri();
    send(); collect(); handoff();

    // Randomized triangles.
    for (int t = 0; t < 12; t++) begin
      rnd_tri();
      send(); collect(); handoff();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
